rx_packet_ctrl: RTL and testbench

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

---
 rtl/rx_ctrl_pkg.sv | 23 ++
 rtl/rx_bit_cnt.sv | 37 +++
 rtl/rx_packet_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rx_packet_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive packet controller.
// Holds the FSM state encoding, the expected sync pattern and the payload limit default.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RX_BITS,
    ST_STORE,
    ST_EOP_WAIT,
    ST_DONE,
    ST_ERR
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE     = 8'h80;
  localparam int         MAX_BYTES_DEF = 64;

  // Bits arrive LSB first, so each new bit enters at the top and the byte shifts right.
  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
    return {b, sh[7:1]};
  endfunction

endpackage

// File: rtl/rx_bit_cnt.sv
// 3-bit bit counter with synchronous clear and enable.
// wrap_o is high while the count sits at 7, i.e. the next enable completes a byte.
module rx_bit_cnt
  import rx_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [2:0] cnt_o,
  output logic       wrap_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == 3'd7);

endmodule

// File: rtl/rx_packet_ctrl.sv
// Receive-side packet controller: checks the sync byte, assembles payload bytes,
// writes them to the receive FIFO and reports clean end of packet or error.
module rx_packet_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_det,
  input  logic       bit_en,
  input  logic       d_bit,
  input  logic       eop,
  input  logic       fifo_full,
  output logic       unstuff_clr,
  output logic [7:0] rx_byte,
  output logic       byte_wr,
  output logic       rcving,
  output logic       rx_done,
  output logic       rx_error,
  output logic [6:0] byte_cnt
);

  localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_wr_q, byte_wr_d;
  logic       rx_error_q, rx_error_d;
  logic       eop_seen_q, eop_seen_d;

  logic       cnt_clr;
  logic       cnt_en;
  logic [2:0] bit_cnt;
  logic       bit_wrap;
  logic [7:0] shift_nxt;
  logic       store_ok;

  rx_bit_cnt u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (bit_cnt),
    .wrap_o (bit_wrap)
  );

  assign shift_nxt = shift_in(shift_q, d_bit);
  assign store_ok  = !fifo_full && ({1'b0, byte_cnt_q} < MAX_B);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    rx_byte_d  = rx_byte_q;
    byte_wr_d  = 1'b0;
    rx_error_d = rx_error_q;
    eop_seen_d = eop_seen_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d    = ST_SYNC;
          cnt_clr    = 1'b1;
          shift_d    = 8'h00;
          byte_cnt_d = 7'd0;
          rx_error_d = 1'b0;
          eop_seen_d = 1'b0;
        end
      end
      ST_SYNC: begin
        if (eop) begin
          state_d = ST_ERR;
        end else if (bit_en) begin
          shift_d = shift_nxt;
          cnt_en  = 1'b1;
          if (bit_wrap) begin
            state_d = (shift_nxt == SYNC_BYTE) ? ST_RX_BITS : ST_ERR;
          end
        end
      end
      ST_RX_BITS: begin
        // eop wins over a same-cycle strobe; a byte boundary is the only clean place to end
        if (eop) begin
          state_d = (bit_cnt == 3'd0) ? ST_EOP_WAIT : ST_ERR;
        end else if (bit_en) begin
          shift_d = shift_nxt;
          cnt_en  = 1'b1;
          if (bit_wrap) begin
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        if (bit_en && !eop) begin
          shift_d = shift_nxt;
          cnt_en  = 1'b1;
        end
        if (store_ok) begin
          byte_wr_d  = 1'b1;
          rx_byte_d  = shift_q;
          byte_cnt_d = byte_cnt_q + 7'd1;
          state_d    = ST_RX_BITS;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_EOP_WAIT: begin
        if (!eop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (eop) begin
          eop_seen_d = 1'b1;
        end else if (eop_seen_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering ERR because of eop counts as having already seen it high.
    if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      rx_error_d = 1'b1;
      eop_seen_d = eop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      byte_cnt_q <= 7'd0;
      rx_byte_q  <= 8'h00;
      byte_wr_q  <= 1'b0;
      rx_error_q <= 1'b0;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      rx_byte_q  <= rx_byte_d;
      byte_wr_q  <= byte_wr_d;
      rx_error_q <= rx_error_d;
      eop_seen_q <= eop_seen_d;
    end
  end

  assign unstuff_clr = (state_q == ST_IDLE) && start_det && !rst;
  assign rcving      = (state_q == ST_SYNC) || (state_q == ST_RX_BITS) ||
                       (state_q == ST_STORE) || (state_q == ST_EOP_WAIT);
  assign rx_done     = (state_q == ST_DONE);
  assign rx_byte     = rx_byte_q;
  assign byte_wr     = byte_wr_q;
  assign rx_error    = rx_error_q;
  assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl: a packet table applied in a loop plus hand-written
// sequences for eop corner cases and mid-packet reset; second instance uses MAX_BYTES=2.
module tb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_det, bit_en, d_bit, eop, fifo_full;

  logic       unstuff_clr, byte_wr, rcving, rx_done, rx_error;
  logic [7:0] rx_byte;
  logic [6:0] byte_cnt;

  logic       unstuff_clr2, byte_wr2, rcving2, rx_done2, rx_error2;
  logic [7:0] rx_byte2;
  logic [6:0] byte_cnt2;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, done_cnt = 0, wr2_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  sync;
    int          nb;
    logic [23:0] bytes;
    int          extra;
    logic        full;
    int          exp_wr;
    int          exp_done;
    logic        exp_err;
    int          exp_cnt;
    int          exp_wr2;
    logic        exp_err2;
    int          exp_cnt2;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  rx_packet_ctrl u_dut (
    .clk(clk), .rst(rst), .start_det(start_det), .bit_en(bit_en), .d_bit(d_bit),
    .eop(eop), .fifo_full(fifo_full), .unstuff_clr(unstuff_clr), .rx_byte(rx_byte),
    .byte_wr(byte_wr), .rcving(rcving), .rx_done(rx_done), .rx_error(rx_error),
    .byte_cnt(byte_cnt)
  );

  rx_packet_ctrl #(.MAX_BYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_det(start_det), .bit_en(bit_en), .d_bit(d_bit),
    .eop(eop), .fifo_full(fifo_full), .unstuff_clr(unstuff_clr2), .rx_byte(rx_byte2),
    .byte_wr(byte_wr2), .rcving(rcving2), .rx_done(rx_done2), .rx_error(rx_error2),
    .byte_cnt(byte_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge, write data checked against exp_q.
  task automatic tick();
    @(posedge clk);
    #1;
    if (byte_wr === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_byte_wr", 32'd1, 32'd0);
      else chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
    end
    if (rx_done === 1'b1) done_cnt++;
    if (byte_wr2 === 1'b1) wr2_cnt++;
  endtask

  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    d_bit  = b;
    tick();
    bit_en = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic start_pkt();
    start_det = 1'b1;
    #1;
    chk("unstuff_clr_pulse", {31'd0, unstuff_clr}, 32'd1);
    tick();
    start_det = 1'b0;
    chk("rcving_after_start", {31'd0, rcving}, 32'd1);
    chk("rx_error_cleared", {31'd0, rx_error}, 32'd0);
    chk("byte_cnt_cleared", {25'd0, byte_cnt}, 32'd0);
  endtask

  task automatic end_pkt();
    eop = 1'b1;
    tick();
    tick();
    eop = 1'b0;
    repeat (4) tick();
  endtask

  task automatic run_vec(input int k);
    int w0, d0, w20;
    vec_t v;
    v = vecs[k];
    w0 = wr_cnt; d0 = done_cnt; w20 = wr2_cnt;
    for (int i = 0; i < v.exp_wr; i++) exp_q.push_back(v.bytes[8*i +: 8]);
    fifo_full = v.full;
    start_pkt();
    send_byte(v.sync);
    for (int i = 0; i < v.nb; i++) send_byte(v.bytes[8*i +: 8]);
    for (int i = 0; i < v.extra; i++) send_bit(1'b1);
    end_pkt();
    fifo_full = 1'b0;
    chk($sformatf("v%0d_writes", k), wr_cnt - w0, v.exp_wr);
    chk($sformatf("v%0d_done", k), done_cnt - d0, v.exp_done);
    chk($sformatf("v%0d_rx_error", k), {31'd0, rx_error}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_byte_cnt", k), {25'd0, byte_cnt}, v.exp_cnt);
    chk($sformatf("v%0d_rcving_low", k), {31'd0, rcving}, 32'd0);
    chk($sformatf("v%0d_pending_exp", k), exp_q.size(), 32'd0);
    chk($sformatf("v%0d_m2_writes", k), wr2_cnt - w20, v.exp_wr2);
    chk($sformatf("v%0d_m2_rx_error", k), {31'd0, rx_error2}, {31'd0, v.exp_err2});
    chk($sformatf("v%0d_m2_byte_cnt", k), {25'd0, byte_cnt2}, v.exp_cnt2);
    exp_q.delete();
  endtask

  initial begin
    int w0, d0;
    //              sync   nb bytes        ex full wr dn err cnt wr2 err2 cnt2
    vecs[0] = '{8'h80, 2, 24'h003CA5, 0, 1'b0, 2, 1, 1'b0, 2, 2, 1'b0, 2};
    vecs[1] = '{8'hC0, 0, 24'h000000, 0, 1'b0, 0, 0, 1'b1, 0, 0, 1'b1, 0};
    vecs[2] = '{8'h80, 0, 24'h000000, 3, 1'b0, 0, 0, 1'b1, 0, 0, 1'b1, 0};
    vecs[3] = '{8'h80, 1, 24'h00005A, 0, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 0};
    vecs[4] = '{8'h80, 3, 24'h80FF01, 0, 1'b0, 3, 1, 1'b0, 3, 2, 1'b1, 2};
    vecs[5] = '{8'h80, 0, 24'h000000, 0, 1'b0, 0, 1, 1'b0, 0, 0, 1'b0, 0};

    rst = 1'b1; start_det = 1'b0; bit_en = 1'b0; d_bit = 1'b0; eop = 1'b0; fifo_full = 1'b0;
    repeat (3) tick();
    chk("reset_byte_wr", {31'd0, byte_wr}, 32'd0);
    chk("reset_rcving", {31'd0, rcving}, 32'd0);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_rx_error", {31'd0, rx_error}, 32'd0);
    chk("reset_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("reset_byte_cnt", {25'd0, byte_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_vec(k);

    // eop and a strobe in the same cycle at a byte boundary: clean end, bit dropped
    w0 = wr_cnt; d0 = done_cnt;
    start_pkt();
    send_byte(8'h80);
    bit_en = 1'b1; d_bit = 1'b1; eop = 1'b1;
    tick();
    bit_en = 1'b0;
    tick();
    eop = 1'b0;
    repeat (4) tick();
    chk("eop_bit_same_done", done_cnt - d0, 32'd1);
    chk("eop_bit_same_err", {31'd0, rx_error}, 32'd0);
    chk("eop_bit_same_wr", wr_cnt - w0, 32'd0);

    // eop during sync
    start_pkt();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    eop = 1'b1;
    tick();
    chk("sync_eop_err", {31'd0, rx_error}, 32'd1);
    chk("sync_eop_rcving", {31'd0, rcving}, 32'd0);
    tick();
    eop = 1'b0;
    repeat (3) tick();
    chk("sync_eop_still_err", {31'd0, rx_error}, 32'd1);

    // reset mid-byte while receiving payload
    exp_q.push_back(8'hA5);
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rcving", {31'd0, rcving}, 32'd0);
    chk("mid_rst_byte_wr", {31'd0, byte_wr}, 32'd0);
    chk("mid_rst_rx_done", {31'd0, rx_done}, 32'd0);
    chk("mid_rst_rx_error", {31'd0, rx_error}, 32'd0);
    chk("mid_rst_unstuff_clr", {31'd0, unstuff_clr}, 32'd0);
    chk("mid_rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("mid_rst_byte_cnt", {25'd0, byte_cnt}, 32'd0);
    w0 = wr_cnt; d0 = done_cnt;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_no_wr", wr_cnt - w0, 32'd0);
    chk("post_rst_no_done", done_cnt - d0, 32'd0);
    exp_q.delete();
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
